// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - edge-detecting, maskable, fixed-priority interrupt controller
// Single request in flight: latched ID is held from assert through handler exit.
module irq_controller #(
  parameter int          NSRC = 4,
  parameter logic [31:0] BASE = 32'h4000_0030
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src_irq,
  input  logic            kernel,
  input  logic            rd,
  input  logic            wr,
  input  logic [31:0]     addr,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic            irq
);

  typedef enum logic [1:0] {IDLE, ASSERT, SERVICE} state_t;

  state_t          state, state_next;
  logic [NSRC-1:0] prev, pend, mask, pend_next, act, ack_clr, w1c_clr, id_mask;
  logic            gen;
  logic [2:0]      id, id_next, low_id;
  logic            sel, wr_sel;
  logic [1:0]      idx;
  logic            unused_bits;

  assign sel    = (addr[31:4] == BASE[31:4]);
  assign idx    = addr[3:2];
  assign wr_sel = wr & sel;
  assign act    = pend & mask;
  assign id_mask = NSRC'(1) << id;
  assign unused_bits = ^{addr[1:0], wdata[31:NSRC]};

  // Scan downward so the lowest set index is the last one written.
  always_comb begin
    low_id = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (act[i]) low_id = 3'(i);
    end
  end

  always_comb begin
    state_next = state;
    id_next    = id;
    ack_clr    = '0;
    case (state)
      IDLE: begin
        if (gen && (|act) && !kernel) begin
          state_next = ASSERT;
          id_next    = low_id;
        end
      end
      ASSERT: begin
        if (kernel) begin
          state_next = SERVICE;
          ack_clr    = id_mask;
        end else if (!gen || !(|(act & id_mask))) begin
          state_next = IDLE;
        end
      end
      SERVICE: begin
        if (!kernel) begin
          state_next = IDLE;
          id_next    = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // New edges are OR-ed in after the clears so a simultaneous set wins.
  assign w1c_clr   = (wr_sel && idx == 2'd0) ? wdata[NSRC-1:0] : '0;
  assign pend_next = (pend & ~(w1c_clr | ack_clr)) | (src_irq & ~prev);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      id    <= '0;
      prev  <= '0;
      pend  <= '0;
      mask  <= '0;
      gen   <= 1'b0;
    end else begin
      state <= state_next;
      id    <= id_next;
      prev  <= src_irq;
      pend  <= pend_next;
      if (wr_sel && idx == 2'd1) mask <= wdata[NSRC-1:0];
      if (wr_sel && idx == 2'd2) gen  <= wdata[0];
    end
  end

  always_comb begin
    rdata = '0;
    if (rd && sel) begin
      case (idx)
        2'd0: rdata[NSRC-1:0] = pend;
        2'd1: rdata[NSRC-1:0] = mask;
        2'd2: rdata[0]        = gen;
        default: begin
          rdata[31]  = (state != IDLE);
          rdata[2:0] = id;
        end
      endcase
    end
  end

  assign irq = (state == ASSERT) & ~kernel;

endmodule

// File: tb/tb_irq_controller.sv
// tb/tb_irq_controller.sv - directed plus randomized bench against a behavioural model
module tb_irq_controller;

  localparam logic [31:0] BASE = 32'h4000_0030;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  src_irq;
  logic        kernel, rd, wr;
  logic [31:0] addr, wdata, rdata;
  logic        irq;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: integers for registers, phase 0 = no request, 1 = waiting for CPU, 2 = handler running.
  int unsigned m_pend, m_mask, m_prev, m_id;
  bit          m_gen;
  int          m_phase;
  bit          m_irq_exp;

  irq_controller #(.NSRC(4), .BASE(BASE)) dut (
    .clk(clk), .reset(reset), .src_irq(src_irq), .kernel(kernel),
    .rd(rd), .wr(wr), .addr(addr), .wdata(wdata), .rdata(rdata), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_pend = 0; m_mask = 0; m_prev = 0; m_id = 0; m_gen = 0; m_phase = 0;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a[31:4] != BASE[31:4]) return 32'h0;
    case (a[3:2])
      2'd0: return m_pend;
      2'd1: return m_mask;
      2'd2: return {31'h0, m_gen};
      default: return (m_phase != 0 ? 32'h8000_0000 : 32'h0) | m_id;
    endcase
  endfunction

  function automatic int lowest(input int unsigned v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Check combinational outputs for the current inputs, then advance model and DUT one edge.
  task automatic step();
    int unsigned rise, act, n_pend, n_mask, n_id;
    bit          n_gen, sel;
    int          n_phase;
    #1;
    m_irq_exp = (m_phase == 1) && !kernel;
    check("irq", {31'h0, irq}, {31'h0, m_irq_exp});
    check("rdata", rdata, rd ? model_read(addr) : 32'h0);
    sel    = (addr[31:4] == BASE[31:4]);
    rise   = src_irq & ~m_prev[3:0];
    act    = m_pend & m_mask;
    n_pend = m_pend; n_mask = m_mask; n_gen = m_gen; n_phase = m_phase; n_id = m_id;
    if (m_phase == 0) begin
      if (m_gen && act != 0 && !kernel) begin
        n_phase = 1;
        n_id = lowest(act);
      end
    end else if (m_phase == 1) begin
      if (kernel) begin
        n_phase = 2;
        n_pend = n_pend & ~(32'h1 << m_id);
      end else if (!m_gen || ((act >> m_id) & 1) == 0) begin
        n_phase = 0;
      end
    end else begin
      if (!kernel) begin
        n_phase = 0;
        n_id = 0;
      end
    end
    if (wr && sel) begin
      case (addr[3:2])
        2'd0: n_pend = n_pend & ~(wdata & 32'hF);
        2'd1: n_mask = wdata & 32'hF;
        2'd2: n_gen  = wdata[0];
        default: ;
      endcase
    end
    n_pend = n_pend | rise;
    @(posedge clk);
    #1;
    m_pend = n_pend; m_mask = n_mask; m_gen = n_gen; m_phase = n_phase; m_id = n_id;
    m_prev = {28'h0, src_irq};
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    wr = 1'b1; addr = a; wdata = d;
    step();
    wr = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    rd = 1'b1; addr = a;
    #1;
    check(tag, rdata, exp);
    rd = 1'b0;
  endtask

  initial begin
    int hold;
    reset = 1'b0; src_irq = '0; kernel = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    model_reset();
    #12;
    rd_chk("reset_cause", BASE + 12, 32'h0);
    rd_chk("reset_ctrl", BASE + 8, 32'h0);
    check("reset_irq", {31'h0, irq}, 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Register access
    bus_write(BASE + 4, 32'hF);
    bus_write(BASE + 8, 32'h1);
    rd_chk("mask_rb", BASE + 4, 32'h0000_000F);
    rd_chk("ctrl_rb", BASE + 8, 32'h0000_0001);
    rd_chk("pend_rb", BASE, 32'h0);
    rd_chk("cause_rb", BASE + 12, 32'h0);
    rd_chk("outside", BASE + 16, 32'h0);

    // Single request on source 2
    src_irq = 4'b0100; step(); src_irq = 4'b0000;
    rd_chk("single_pend", BASE, 32'h4);
    check("single_irq_early", {31'h0, irq}, 32'h0);
    step();
    check("single_irq", {31'h0, irq}, 32'h1);
    rd_chk("single_cause", BASE + 12, 32'h8000_0002);
    kernel = 1'b1; #1;
    check("ack_irq_drop", {31'h0, irq}, 32'h0);
    step();
    rd_chk("ack_pend_clr", BASE, 32'h0);
    kernel = 1'b0; step();
    rd_chk("handler_done", BASE + 12, 32'h0);

    // Priority: 3 and 1 together
    src_irq = 4'b1010; step(); src_irq = 4'b0000; step();
    rd_chk("prio_first", BASE + 12, 32'h8000_0001);
    kernel = 1'b1; step(); step();
    kernel = 1'b0; step();
    check("rearm_gap", {31'h0, irq}, 32'h0);
    step();
    rd_chk("prio_second", BASE + 12, 32'h8000_0003);
    kernel = 1'b1; step(); step(); kernel = 1'b0; step();

    // Masking and global enable
    bus_write(BASE + 4, 32'h0);
    src_irq = 4'b0001; step(); src_irq = 4'b0000; step(); step();
    rd_chk("masked_pend", BASE, 32'h1);
    check("masked_irq", {31'h0, irq}, 32'h0);
    bus_write(BASE + 4, 32'h1);
    step();
    check("unmask_irq", {31'h0, irq}, 32'h1);
    bus_write(BASE + 8, 32'h0);
    check("gen_off_same_edge", {31'h0, irq}, 32'h1);
    step();
    check("gen_off_irq", {31'h0, irq}, 32'h0);
    rd_chk("gen_off_pend", BASE, 32'h1);

    // Collisions
    src_irq = 4'b0001; bus_write(BASE, 32'h1);
    rd_chk("w1c_vs_set", BASE, 32'h1);
    bus_write(BASE, 32'h1); step(); step();
    rd_chk("level_once", BASE, 32'h0);
    src_irq = 4'b0000; step();

    // Async reset while servicing with PEND=6
    bus_write(BASE + 4, 32'hF);
    bus_write(BASE + 8, 32'h1);
    src_irq = 4'b0110; step(); src_irq = 4'b0000; step();
    kernel = 1'b1; step();
    src_irq = 4'b0010; step(); src_irq = 4'b0000;
    rd_chk("svc_pend", BASE, 32'h6);
    reset = 1'b0; model_reset(); #1;
    check("areset_irq", {31'h0, irq}, 32'h0);
    rd_chk("areset_pend", BASE, 32'h0);
    rd_chk("areset_mask", BASE + 4, 32'h0);
    rd_chk("areset_cause", BASE + 12, 32'h0);
    kernel = 1'b0; src_irq = 4'b0001;
    reset = 1'b1;
    step();
    rd_chk("held_src_pend", BASE, 32'h1);

    // Randomized traffic with a CPU-like kernel response
    bus_write(BASE + 4, 32'hF);
    bus_write(BASE + 8, 32'h1);
    hold = 0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) src_irq = src_irq ^ 4'($urandom_range(0, 15));
      if (kernel) begin
        hold--;
        if (hold <= 0) kernel = 1'b0;
      end else if (m_irq_exp) begin
        kernel = 1'b1;
        hold = $urandom_range(1, 4);
      end
      wr = ($urandom_range(0, 7) == 0);
      addr = BASE + 32'($urandom_range(0, 3) * 4);
      if ($urandom_range(0, 9) == 0) addr = BASE ^ (32'h10 << $urandom_range(0, 27));
      wdata = $urandom;
      if (addr[3:2] == 2'd2) wdata[0] = ($urandom_range(0, 3) != 0);
      if (addr[3:2] == 2'd1) wdata[3:0] = wdata[3:0] | 4'($urandom_range(0, 15));
      rd = ($urandom_range(0, 1) == 1);
      step();
    end
    wr = 1'b0; rd = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
# irq_controller

Memory-mapped interrupt controller between the peripheral interrupt sources (timer, UART RX, UART TX, switches) and the single-cycle CPU's `IRQ` input. It edge-detects up to eight source lines into a pending register and applies a per-source mask and a global enable. It selects the lowest-numbered pending source and drives `irq` until the CPU enters kernel mode (PC[31]=1), then holds off further requests until the handler returns. It sits in peripheral address space beside the Peripheral block and shares its `rd`/`wr`/`addr`/`wdata`/`rdata` bus.

## Interface
- NSRC, 4: number of source lines, 1..8.
- BASE, 32'h4000_0030: register block base address, 16-byte aligned.

- clk  in  1  system clock, same as CPU.
- reset  in  1  asynchronous, active-low.
- src_irq  in  NSRC  source request lines; a rising edge raises a request.
- kernel  in  1  CPU PC[31]; 1 while the handler runs.
- rd  in  1  bus read strobe.
- wr  in  1  bus write strobe, sampled on posedge clk.
- addr  in  32  bus address.
- wdata  in  32  bus write data.
- rdata  out  32  bus read data; combinational.
- irq  out  1  interrupt request to the CPU Control block.

## Operation
- Select: `sel = (addr[31:4] == BASE[31:4])`. Register index is `addr[3:2]`.
  - 0 PEND: read-only view; a write clears every bit set in `wdata` (write-1-to-clear).
  - 1 MASK: read/write; 1 enables the source.
  - 2 CTRL: read/write; bit0 is the global enable GEN, other bits read 0.
  - 3 CAUSE: read-only; bit31 = VALID, bits[2:0] = ID, others 0.
- `rdata = (rd & sel) ? reg : 0`. Bits at and above NSRC in PEND and MASK read 0.
- Edge detect: `prev <= src_irq` every cycle. `PEND[i]` is set when `src_irq[i] & ~prev[i]`.
- Active set: `act = PEND & MASK`.
- State machine, states IDLE, ASSERT, SERVICE:
  - IDLE → ASSERT when GEN=1, act≠0 and kernel=0. On that edge, CAUSE.ID latches the lowest index set in `act`.
  - ASSERT → SERVICE when kernel=1. On that edge, `PEND[ID]` is cleared.
  - ASSERT → IDLE when GEN=0 or `act[ID]=0` (software cleared or masked it). CAUSE.ID is kept.
  - SERVICE → IDLE when kernel=0 (handler returned).
- Outputs:
  - `irq = (state==ASSERT) & ~kernel`, registered state only, so it does not glitch.
  - CAUSE.VALID = (state != IDLE).
- Priority: fixed, index 0 highest. It is evaluated only on the IDLE→ASSERT edge. A higher-priority source arriving during ASSERT does not replace ID.
- Simultaneous events:
  - A new rising edge on the same cycle as a W1C or acknowledge clear of that bit: set wins, bit stays 1.
  - A MASK or CTRL write and a state transition on the same edge: the transition uses the pre-write values.

## Timing
- Reset (asynchronous, reset=0): PEND=0, MASK=0, CTRL=0, CAUSE=0, prev=0, state=IDLE, irq=0, rdata=0.
  - Because prev resets to 0, a source already high at reset release sets PEND one clock after release.
- Reset mid-operation: everything above takes effect immediately; any request in progress is dropped.
- Latency:
  - Source rising edge at edge N: PEND set at edge N+1.
  - With GEN and MASK already 1: state=ASSERT and irq=1 after edge N+2.
- Acknowledge: the CPU jumps to the handler on the edge where irq=1, so kernel=1 in the next cycle. irq then falls combinationally, and state=SERVICE after the following edge.
- Re-arm: at least one cycle in IDLE between SERVICE and the next ASSERT. After kernel falls, irq can be 1 no earlier than two edges later.
- Register writes take effect on the posedge where wr & sel = 1. Reads are zero-wait.

## Test plan
- Reset and access: write MASK=0xF and CTRL=1, read them back as 0x0000000F and 0x00000001. Read PEND=0 and CAUSE=0. Read an address outside the block → rdata=0.
- Single request: pulse src_irq[2] for one cycle → PEND=0x4 one edge later, irq=1 one edge after that, CAUSE=0x80000002. Raise kernel → irq=0 immediately, PEND=0 next edge. Drop kernel → CAUSE=0.
- Priority: raise src_irq[3] and src_irq[1] on the same edge → CAUSE.ID=1. After that service completes, a second ASSERT with ID=3, no earlier than two edges after kernel falls.
- Masking and enable:
  - MASK=0x0 with an edge on src_irq[0] → PEND=0x1, irq stays 0.
  - Set MASK=0x1 → irq=1 two edges later.
  - Write CTRL=0 during ASSERT → irq=0 next edge, PEND still 0x1.
- Collisions:
  - W1C of PEND bit 0 on the same edge as a new src_irq[0] rising edge → PEND bit 0 stays 1.
  - Level-held src_irq raises only one request.
- Async reset asserted while in SERVICE with PEND=0x6 → all registers 0 and irq=0 without a clock. After release with src_irq[0] held high → PEND=0x1 after the first edge.
